clk_div_mon: RTL

Clock-period monitor for divided clocks in the 8051 system. The block samples a slow clock produced elsewhere in the design (nominally the 50 MHz divided output) in the `clk_in` domain and measures each half-period in `clk_in` cycles. It flags half-periods outside a tolerance window, detects a stuck clock, and keeps a saturating error count for the debug/status logic.

---
 rtl/clk_div_mon_if.sv | 15 +
 rtl/clk_div_mon.sv | 81 ++++++++
 2 files changed

// File: rtl/clk_div_mon_if.sv
// clk_div_mon_if: monitored clock, controls and measurement results of clk_div_mon
interface clk_div_mon_if #(parameter int CNT_WIDTH = 8);
    logic                 mon_in;
    logic                 enable;
    logic                 err_clr;
    logic [CNT_WIDTH-1:0] half_period;
    logic                 meas_valid;
    logic                 in_range;
    logic                 stuck;
    logic [7:0]           err_cnt;
    modport master (output mon_in, enable, err_clr,
                    input  half_period, meas_valid, in_range, stuck, err_cnt);
    modport slave  (input  mon_in, enable, err_clr,
                    output half_period, meas_valid, in_range, stuck, err_cnt);
endinterface

// File: rtl/clk_div_mon.sv
// clk_div_mon: measures half-periods of a slow clock in the clk_in domain,
// flags out-of-window and stuck conditions and counts them with saturation
module clk_div_mon #(
    parameter int CNT_WIDTH = 8,
    parameter int EXP_HALF  = 3,
    parameter int TOL       = 1,
    parameter int TIMEOUT   = 64
) (
    input logic          clk_in,
    input logic          rst_n,
    clk_div_mon_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE} state_t;
    // window bounds kept as int so a negative lower bound cannot wrap
    localparam int LO = EXP_HALF - TOL;
    localparam int HI = EXP_HALF + TOL;
    localparam logic [CNT_WIDTH-1:0] TO  = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    state_t               state, state_nxt;
    logic                 s1, s2, s3, edge_det;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_sat;
    logic                 do_meas, set_stuck, clr_stuck, win, err_evt;

    assign edge_det = s2 ^ s3;
    assign cnt_sat  = &cnt ? cnt : cnt + ONE;
    assign win      = (int'(cnt) >= LO) && (int'(cnt) <= HI);
    assign err_evt  = (do_meas && !win) || (set_stuck && !bus.stuck);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_sat;
        do_meas   = 1'b0;
        set_stuck = 1'b0;
        clr_stuck = 1'b0;
        if (!bus.enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            clr_stuck = 1'b1;
        end else if (state == IDLE) begin
            state_nxt = ACQUIRE;
            cnt_nxt   = '0;
        end else if (edge_det) begin
            state_nxt = MEASURE;
            cnt_nxt   = ONE;
            clr_stuck = 1'b1;
            do_meas   = (state == MEASURE);
        end else if (cnt == TO) begin
            state_nxt = ACQUIRE;
            set_stuck = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1              <= 1'b0;
            s2              <= 1'b0;
            s3              <= 1'b0;
            state           <= IDLE;
            cnt             <= '0;
            bus.half_period <= '0;
            bus.meas_valid  <= 1'b0;
            bus.in_range    <= 1'b0;
            bus.stuck       <= 1'b0;
            bus.err_cnt     <= '0;
        end else begin
            s1             <= bus.mon_in;
            s2             <= s1;
            s3             <= s2;
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bus.meas_valid <= do_meas;
            if (do_meas) begin
                bus.half_period <= cnt;
                bus.in_range    <= win;
            end
            bus.stuck   <= set_stuck | (bus.stuck & ~clr_stuck);
            bus.err_cnt <= bus.err_clr ? '0 :
                           (err_evt && !(&bus.err_cnt)) ? bus.err_cnt + 8'd1 : bus.err_cnt;
        end
    end
endmodule
